// File: rtl/chmu_hotlist_reader.sv
// chmu_hotlist_reader
// Consumer side of the tracker's migration list. A host request or an epoch
// expiry triggers a one-cycle query to the tracker. The returned {addr,cnt}
// stream is then drained into a show-ahead FIFO that the host side pops.
// Entries whose count is zero are dropped instead of being buffered.

module chmu_hotlist_reader #(
  parameter int ADDR_SIZE     = 21,
  parameter int CNT_SIZE      = 12,
  parameter int LIST_SIZE     = 32,
  parameter int FIFO_DEPTH    = 32,
  parameter int EPOCH_CYCLES  = 100000,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              host_query_req,
  output logic                              query_en,
  input  logic                              query_ready,
  input  logic                              mig_addr_cnt_en,
  input  logic [ADDR_SIZE+CNT_SIZE-1:0]     mig_addr_cnt,
  output logic                              mig_addr_cnt_ready,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [ADDR_SIZE+CNT_SIZE-1:0]     rd_data,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              drain_busy,
  output logic                              drain_done,
  output logic [$clog2(LIST_SIZE):0]        drain_entries
);

  localparam int DW = ADDR_SIZE + CNT_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(LIST_SIZE) + 1;
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int EW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LIST_C    = AW'(LIST_SIZE);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          pending;
  logic          pending_set;
  logic          epoch_expire;

  logic [AW-1:0] acc_cnt;
  logic [AW-1:0] acc_cnt_nxt;
  logic [AW-1:0] wr_cnt;
  logic [IW-1:0] idle_cnt;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          beat_cnt_zero;
  logic          list_hit;
  logic          timeout_hit;

  // Handshake and end-of-drain terms; ready only looks at registered occupancy
  assign ready         = (state == DRAIN) && (fifo_count < DEPTH_C);
  assign accept        = mig_addr_cnt_en && ready;
  assign beat_cnt_zero = (mig_addr_cnt[CNT_SIZE-1:0] == '0);
  assign push          = accept && !beat_cnt_zero;
  assign pop           = rd_en && (fifo_count != '0);
  assign pending_set   = host_query_req || epoch_expire;
  assign acc_cnt_nxt   = acc_cnt + AW'(1);
  assign list_hit      = accept && (acc_cnt_nxt == LIST_C);
  assign timeout_hit   = (idle_cnt == TIMEOUT_C);

  assign mig_addr_cnt_ready = ready;
  assign rd_valid           = (fifo_count != '0);
  assign rd_data            = rd_valid ? mem[rd_ptr] : '0;
  assign drain_busy         = (state == REQ) || (state == DRAIN);
  assign drain_done         = (state == DONE);

  generate
    if (EPOCH_CYCLES != 0) begin : g_epoch
      localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCH_CYCLES - 1);
      logic [EW-1:0] epoch_cnt;

      // Free-running epoch counter that wraps after EPOCH_CYCLES cycles
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          epoch_cnt <= '0;
        end else if (epoch_cnt == EPOCH_LAST) begin
          epoch_cnt <= '0;
        end else begin
          epoch_cnt <= epoch_cnt + EW'(1);
        end
      end

      assign epoch_expire = (epoch_cnt == EPOCH_LAST);
    end else begin : g_no_epoch
      assign epoch_expire = 1'b0;
    end
  endgenerate

  // Single queued-query flag; a new request in the issuing cycle stays queued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending && !query_en) || pending_set;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and the combinational query strobe
  always_comb begin
    state_nxt = state;
    query_en  = 1'b0;
    case (state)
      IDLE: begin
        if (pending || pending_set) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        query_en = query_ready;
        if (query_ready) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (list_hit || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Per-drain counters; idle only advances while the FIFO can take a beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      idle_cnt <= '0;
    end else if (query_en) begin
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      idle_cnt <= '0;
    end else if (state == DRAIN) begin
      if (accept) begin
        acc_cnt  <= acc_cnt_nxt;
        idle_cnt <= '0;
        if (push) begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end else if (ready && !timeout_hit) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  // Latch the number of buffered entries when a drain completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_entries <= '0;
    end else if (state == DONE) begin
      drain_entries <= wr_cnt;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are not reset, occupancy alone marks them valid
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= mig_addr_cnt;
    end
  end

endmodule

// File: tb/tb_chmu_hotlist_reader.sv
// tb_chmu_hotlist_reader
// Scoreboard bench: accepted nonzero beats are queued as expected FIFO output
// and compared when popped. A second instance with a 200-cycle epoch checks
// the periodic query timing.

`timescale 1ns/1ps

module tb_chmu_hotlist_reader;

  localparam int AS = 21;
  localparam int CS = 12;
  localparam int DW = AS + CS;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   done_pulses = 0;
  int   ep_start = 0;

  // Main instance: small FIFO, epoch timer disabled
  logic          rst_n;
  logic          host_req;
  logic          query_en;
  logic          qready;
  logic          mig_en;
  logic [DW-1:0] mig_data;
  logic          rdy;
  logic          rd_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [2:0]    fifo_count;
  logic          busy;
  logic          done;
  logic [5:0]    entries;

  // Epoch instance: idle host, tracker always ready, no beats
  logic          ep_rst_n;
  logic          ep_zero;
  logic          ep_qready;
  logic [DW-1:0] ep_data;
  logic          ep_qen;
  logic          ep_rdy;
  logic          ep_rd_valid;
  logic [DW-1:0] ep_rd_data;
  logic [5:0]    ep_fifo_count;
  logic          ep_busy;
  logic          ep_done;
  logic [5:0]    ep_entries;

  logic [DW-1:0] sb[$];
  int            ep_q[$];

  chmu_hotlist_reader #(
    .ADDR_SIZE(AS), .CNT_SIZE(CS), .LIST_SIZE(32), .FIFO_DEPTH(4),
    .EPOCH_CYCLES(0), .DRAIN_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host_query_req(host_req),
    .query_en(query_en), .query_ready(qready),
    .mig_addr_cnt_en(mig_en), .mig_addr_cnt(mig_data),
    .mig_addr_cnt_ready(rdy), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .fifo_count(fifo_count), .drain_busy(busy),
    .drain_done(done), .drain_entries(entries)
  );

  chmu_hotlist_reader #(
    .ADDR_SIZE(AS), .CNT_SIZE(CS), .LIST_SIZE(32), .FIFO_DEPTH(32),
    .EPOCH_CYCLES(200), .DRAIN_TIMEOUT(64)
  ) dut_ep (
    .clk(clk), .rst_n(ep_rst_n), .host_query_req(ep_zero),
    .query_en(ep_qen), .query_ready(ep_qready),
    .mig_addr_cnt_en(ep_zero), .mig_addr_cnt(ep_data),
    .mig_addr_cnt_ready(ep_rdy), .rd_en(ep_zero), .rd_valid(ep_rd_valid),
    .rd_data(ep_rd_data), .fifo_count(ep_fifo_count), .drain_busy(ep_busy),
    .drain_done(ep_done), .drain_entries(ep_entries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_pulses <= done_pulses + 1;
    if (ep_qen) ep_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one beat and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [AS-1:0] a, input logic [CS-1:0] c);
    int n = 0;
    mig_en   = 1'b1;
    mig_data = {a, c};
    while (!rdy && n < 300) begin
      step();
      n++;
    end
    checkOutput("beat ready", {63'd0, rdy}, 64'd1);
    if (rdy && c != '0) sb.push_back({a, c});
    step();
    mig_en = 1'b0;
  endtask

  task automatic startQuery();
    qready   = 1'b1;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    checkOutput("query_en in REQ", {63'd0, query_en}, 64'd1);
    step();
    checkOutput("query_en one cycle", {63'd0, query_en}, 64'd0);
    checkOutput("ready in DRAIN", {63'd0, rdy}, 64'd1);
  endtask

  task automatic popCheck(input string tag);
    checkOutput({tag, " valid"}, {63'd0, rd_valid}, 64'd1);
    if (sb.size() > 0) checkOutput(tag, {31'd0, rd_data}, {31'd0, sb.pop_front()});
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    checkOutput("drain_done seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int n;
    int t_start;
    int pulses_before;

    rst_n = 1'b0; ep_rst_n = 1'b0;
    host_req = 1'b0; qready = 1'b0; mig_en = 1'b0; mig_data = '0; rd_en = 1'b0;
    ep_zero = 1'b0; ep_qready = 1'b1; ep_data = '0;
    repeat (3) step();

    checkOutput("rst query_en", {63'd0, query_en}, 64'd0);
    checkOutput("rst ready", {63'd0, rdy}, 64'd0);
    checkOutput("rst rd_valid", {63'd0, rd_valid}, 64'd0);
    checkOutput("rst rd_data", {31'd0, rd_data}, 64'd0);
    checkOutput("rst fifo_count", {61'd0, fifo_count}, 64'd0);
    checkOutput("rst busy", {63'd0, busy}, 64'd0);
    checkOutput("rst done", {63'd0, done}, 64'd0);
    checkOutput("rst entries", {58'd0, entries}, 64'd0);

    rst_n = 1'b1; ep_rst_n = 1'b1;
    ep_start = cyc;
    step();

    $display("[TB] basic drain");
    startQuery();
    applyStimulus(21'h00010, 12'd5);
    applyStimulus(21'h00020, 12'd7);
    applyStimulus(21'h00030, 12'd9);
    waitDone(n);
    checkOutput("basic timeout latency", 64'(n), 64'd65);
    step();
    checkOutput("basic done one cycle", {63'd0, done}, 64'd0);
    checkOutput("basic entries", {58'd0, entries}, 64'd3);
    checkOutput("basic fifo_count", {61'd0, fifo_count}, 64'd3);
    for (int i = 0; i < 3; i++) popCheck("basic pop");
    checkOutput("basic empty", {63'd0, rd_valid}, 64'd0);

    $display("[TB] full list");
    startQuery();
    t_start = cyc;
    fork
      begin
        for (int i = 0; i < 32; i++) applyStimulus(21'(32'h100 + i), 12'(i + 1));
        checkOutput("full elapsed", 64'(cyc - t_start), 64'd32);
        checkOutput("full done on last beat", {63'd0, done}, 64'd1);
        checkOutput("full ready low", {63'd0, rdy}, 64'd0);
      end
      begin
        int popped = 0;
        int k = 0;
        while (popped < 32 && k < 300) begin
          if (rd_valid) begin
            if (sb.size() > 0) checkOutput("full pop data", {31'd0, rd_data}, {31'd0, sb.pop_front()});
            popped++;
            rd_en = 1'b1;
          end else begin
            rd_en = 1'b0;
          end
          step();
          k++;
        end
        rd_en = 1'b0;
        checkOutput("full popped", 64'(popped), 64'd32);
      end
    join
    checkOutput("full entries", {58'd0, entries}, 64'd32);
    mig_en = 1'b1; mig_data = {21'h1ABCD, 12'd4};
    repeat (3) step();
    mig_en = 1'b0;
    checkOutput("beats ignored outside drain", {61'd0, fifo_count}, 64'd0);

    $display("[TB] backpressure");
    startQuery();
    for (int i = 0; i < 4; i++) applyStimulus(21'(32'h200 + i), 12'(i + 10));
    checkOutput("bp full count", {61'd0, fifo_count}, 64'd4);
    checkOutput("bp ready low", {63'd0, rdy}, 64'd0);
    pulses_before = done_pulses;
    repeat (100) step();
    checkOutput("bp still busy", {63'd0, busy}, 64'd1);
    checkOutput("bp no timeout", 64'(done_pulses), 64'(pulses_before));
    popCheck("bp pop");
    popCheck("bp pop");
    applyStimulus(21'h00204, 12'd14);
    applyStimulus(21'h00205, 12'd15);
    for (int i = 0; i < 4; i++) popCheck("bp pop");
    waitDone(n);
    step();
    checkOutput("bp entries", {58'd0, entries}, 64'd6);

    $display("[TB] zero filter");
    startQuery();
    applyStimulus(21'h00040, 12'd0);
    applyStimulus(21'h00050, 12'd3);
    applyStimulus(21'h00060, 12'd0);
    waitDone(n);
    step();
    checkOutput("zf entries", {58'd0, entries}, 64'd1);
    checkOutput("zf fifo_count", {61'd0, fifo_count}, 64'd1);
    popCheck("zf pop");
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checkOutput("pop on empty count", {61'd0, fifo_count}, 64'd0);
    checkOutput("pop on empty valid", {63'd0, rd_valid}, 64'd0);

    $display("[TB] pending query");
    startQuery();
    repeat (5) step();
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    waitDone(n);
    checkOutput("pending drain latency", 64'(n), 64'd59);
    step();
    checkOutput("pending idle gap", {63'd0, query_en}, 64'd0);
    step();
    checkOutput("pending requery", {63'd0, query_en}, 64'd1);
    step();
    waitDone(n);
    step();
    checkOutput("pending empty entries", {58'd0, entries}, 64'd0);
    repeat (3) step();
    checkOutput("no third query", {63'd0, busy}, 64'd0);

    $display("[TB] query_ready low");
    qready = 1'b0;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    repeat (10) step();
    checkOutput("hold REQ busy", {63'd0, busy}, 64'd1);
    checkOutput("hold REQ no query", {63'd0, query_en}, 64'd0);
    checkOutput("hold REQ ready low", {63'd0, rdy}, 64'd0);
    qready = 1'b1;
    #1;
    checkOutput("release query_en", {63'd0, query_en}, 64'd1);
    step();
    checkOutput("release drain ready", {63'd0, rdy}, 64'd1);
    waitDone(n);
    checkOutput("pure timeout latency", 64'(n), 64'd65);

    $display("[TB] reset mid-drain");
    step();
    startQuery();
    applyStimulus(21'h00300, 12'd1);
    applyStimulus(21'h00301, 12'd2);
    checkOutput("pre-reset count", {61'd0, fifo_count}, 64'd2);
    pulses_before = done_pulses;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("reset count", {61'd0, fifo_count}, 64'd0);
    checkOutput("reset valid", {63'd0, rd_valid}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset ready", {63'd0, rdy}, 64'd0);
    checkOutput("reset entries", {58'd0, entries}, 64'd0);
    sb.delete();
    repeat (100) step();
    checkOutput("reset no done", 64'(done_pulses), 64'(pulses_before));
    checkOutput("reset stays idle", {63'd0, busy}, 64'd0);

    $display("[TB] epoch timer");
    n = 0;
    while (cyc < ep_start + 850 && n < 2000) begin
      step();
      n++;
    end
    checkOutput("epoch query count", {63'd0, ep_q.size() >= 4}, 64'd1);
    if (ep_q.size() >= 4) begin
      checkOutput("epoch first query", 64'(ep_q[0]), 64'(ep_start + 200));
      for (int i = 1; i < 4; i++) checkOutput("epoch period", 64'(ep_q[i] - ep_q[i-1]), 64'd200);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
